// File: rtl/div_sequencer.sv
// div_sequencer: sequences the iterative divider for DIV/DIVU in execute.
// It latches operands, holds the stall, and presents a one-cycle qualified HI/LO.
module div_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_req_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   srca_i,
  input  logic [WIDTH-1:0]   srcb_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               div_start_o,
  output logic               div_annul_o,
  output logic               div_signed_o,
  output logic [WIDTH-1:0]   div_a_o,
  output logic [WIDTH-1:0]   div_b_o,
  input  logic               div_ready_i,
  input  logic [2*WIDTH-1:0] div_result_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               res_valid_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   busy_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               launch, expire;
  assign launch = state_q == IDLE && div_req_i && !flush_i;
  assign expire = state_q == RUN && !flush_i && !div_ready_i && cnt_q == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (launch) begin
      sgn_d   = signed_i;
      a_d     = srca_i;
      b_d     = srcb_i;
      cnt_d   = '0;
      state_d = srcb_i == '0 ? DONE : RUN;
      if (srcb_i == '0) begin
        hi_d = srca_i;
        lo_d = '1;
      end
    end
    if (state_q == RUN) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      if (flush_i) state_d = IDLE;
      else if (div_ready_i) begin
        state_d = DONE;
        hi_d    = div_result_i[2*WIDTH-1:WIDTH];
        lo_d    = div_result_i[WIDTH-1:0];
      end else if (expire) begin
        state_d = IDLE;
        hi_d    = '0;
        lo_d    = '0;
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end
  // stall is combinational, so it is gated by reset to keep every output low in reset
  assign stall_o      = rst && div_req_i && !flush_i && (state_q == IDLE || (state_q == RUN && !expire));
  assign div_start_o  = state_q == RUN;
  assign div_annul_o  = state_q == RUN && (flush_i || expire);
  assign timeout_o    = expire;
  assign res_valid_o  = state_q == DONE && !flush_i;
  assign div_signed_o = sgn_q;
  assign div_a_o      = a_q;
  assign div_b_o      = b_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign busy_cnt_o   = cnt_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed bench with a behavioural divider and a result scoreboard.
module tb_div_sequencer;
  logic        clk = 0, rst = 0;
  logic        div_req_i = 0, signed_i = 0, flush_i = 0;
  logic [31:0] srca_i = 0, srcb_i = 0;
  logic        stall_o, div_start_o, div_annul_o, div_signed_o, div_ready_i;
  logic [31:0] div_a_o, div_b_o, hi_o, lo_o, q_m, r_m;
  logic [63:0] div_result_i;
  logic        res_valid_o, timeout_o;
  logic [5:0]  busy_cnt_o, dcnt;
  int          lat = 34, n_tests = 0, n_fail = 0, rvs = 0, stalls = 0, sgn_bad = 0, run_cyc = 0;
  bit          hang = 0, start_seen = 0, got_to;
  logic [63:0] exp_q[$], got_q[$];

  div_sequencer dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .signed_i(signed_i),
    .srca_i(srca_i), .srcb_i(srcb_i), .flush_i(flush_i), .stall_o(stall_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_ready_i(div_ready_i),
    .div_result_i(div_result_i), .hi_o(hi_o), .lo_o(lo_o), .res_valid_o(res_valid_o),
    .timeout_o(timeout_o), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk = ~clk;

  // behavioural divider: ready after lat cycles of start, result from its own inputs
  always @(posedge clk or negedge rst)
    if (!rst) dcnt <= 0;
    else dcnt <= div_start_o ? dcnt + 6'd1 : 6'd0;
  always_comb begin
    q_m = 0;
    r_m = 0;
    if (div_b_o != 0) begin
      q_m = div_signed_o ? 32'($signed(div_a_o) / $signed(div_b_o)) : div_a_o / div_b_o;
      r_m = div_signed_o ? 32'($signed(div_a_o) % $signed(div_b_o)) : div_a_o % div_b_o;
    end
  end
  assign div_result_i = {r_m, q_m};
  assign div_ready_i  = div_start_o && !hang && int'(dcnt) == lat - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // launch a divide and wait until DONE; req is left high (held through DONE)
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
    signed_i = s; srca_i = a; srcb_i = b; div_req_i = 1;
    exp_q.push_back({ehi, elo});
    stalls = 0; sgn_bad = 0; start_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid_o) begin
        got_q.push_back({hi_o, lo_o});
        rvs++;
        break;
      end
      if (stall_o) stalls++;
      if (div_start_o) start_seen = 1;
      if (div_start_o && div_signed_o !== s) sgn_bad++;
      step();
    end
    step();
  endtask

  task automatic idle(input int n);
    div_req_i = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (res_valid_o) rvs++;
      step();
    end
  endtask

  task automatic chk_res(input string tag);
    n_tests++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=no_result expected=%0d_results", tag, exp_q.size());
      exp_q.delete();
    end else begin
      n_tests--;
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    div_req_i = 1; srcb_i = 1;
    @(negedge clk);
    chk("reset_stall", 64'(stall_o), 0);
    chk("reset_outs", {div_start_o, div_annul_o, res_valid_o, timeout_o, busy_cnt_o}, 0);
    chk("reset_hilo", {hi_o, lo_o}, 0);
    div_req_i = 0;
    step();
    rst = 1;
    step();

    run_div(0, 100, 7, 2, 14);
    chk("divu_stalls", 64'(stalls), 35);
    chk("divu_busy", 64'(busy_cnt_o), 34);
    idle(3);
    chk_res("divu_result");
    chk("divu_pulses", 64'(rvs), 1);

    lat = 5;
    run_div(1, -32'sd7, 2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    chk("div_signed_run", 64'(sgn_bad), 0);
    idle(3);
    chk_res("div_neg_result");
    chk("div_neg_pulses", 64'(rvs), 2);

    run_div(1, 5, 0, 5, 32'hFFFFFFFF);
    chk("dz_stalls", 64'(stalls), 1);
    chk("dz_no_start", 64'(start_seen), 0);
    idle(3);
    chk_res("dz_result");
    chk("dz_pulses", 64'(rvs), 3);

    lat = 34;
    signed_i = 0; srca_i = 50; srcb_i = 5; div_req_i = 1;
    repeat (11) step();
    flush_i = 1;
    @(negedge clk);
    chk("flush_annul", {div_annul_o, stall_o}, 64'b10);
    step();
    flush_i = 0; div_req_i = 0;
    @(negedge clk);
    chk("flush_idle", {div_annul_o, div_start_o, stall_o, timeout_o}, 0);
    step();
    idle(2);
    chk("flush_no_result", 64'(rvs), 3);
    lat = 4;
    run_div(0, 50, 5, 0, 10);
    idle(2);
    chk_res("after_flush_result");

    hang = 1; got_to = 0; run_cyc = 0;
    signed_i = 0; srca_i = 1; srcb_i = 1; div_req_i = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_start_o) run_cyc++;
      if (timeout_o) begin
        got_to = 1;
        chk("to_annul_nostall", {div_annul_o, stall_o}, 64'b10);
        break;
      end
      step();
    end
    chk("to_seen", 64'(got_to), 1);
    chk("to_run_cycles", 64'(run_cyc), 40);
    step();
    div_req_i = 0;
    @(negedge clk);
    chk("to_idle", {timeout_o, div_annul_o, div_start_o, stall_o}, 0);
    chk("to_hilo", {hi_o, lo_o}, 0);
    step();
    idle(3);
    chk("to_no_result", 64'(rvs), 4);
    hang = 0;

    lat = 34;
    signed_i = 0; srca_i = 9; srcb_i = 3; div_req_i = 1;
    repeat (6) step();
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_run", {stall_o, div_start_o, div_annul_o, res_valid_o, timeout_o, busy_cnt_o}, 0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 0);
    div_req_i = 0;
    step();
    rst = 1;
    step();
    lat = 3;
    run_div(0, 9, 3, 0, 3);
    run_div(0, 8, 2, 0, 4);
    idle(4);
    chk_res("b2b_first");
    chk_res("b2b_second");
    chk("b2b_pulses", 64'(rvs), 6);
    @(negedge clk);
    chk("b2b_quiet", {div_start_o, stall_o, res_valid_o}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
